// File: rtl/fetch_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : fetch_stage                                                    |
// | Brief    : PC + req/ack instruction fetch with IR buffering and redirect. |
// |            Optional macro FETCH_TIMEOUT_EN bounds the wait for mem_ack.   |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module fetch_stage #(
  parameter int                ADDR_W      = 8,
  parameter int                INST_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [5:0]        inst_enable,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [INST_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              stall,
  output logic              fetch_err
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_wait = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [INST_W-1:0] r_ir;
  logic              r_ir_valid;
  logic [INST_W-1:0] r_buf;
  logic              r_kill;

  logic              w_fetch_permit;
  logic              w_load_permit;
  logic              w_ack;
  logic              w_timeout;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_unused_ie;

  assign w_fetch_permit = inst_enable[5];
  assign w_load_permit  = inst_enable[4];
  assign w_ack          = r_mem_req & mem_ack;
  assign w_pc_inc       = r_pc + ADDR_W'(1);
  assign w_unused_ie    = ^inst_enable[3:0];

`ifdef FETCH_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);

  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_fetch_err;

  assign w_timeout = (r_state == c_st_wait) && !w_ack &&
                     (r_wait_cnt == c_cnt_w'(TIMEOUT_CYC - 1));
  assign fetch_err = r_fetch_err;

  // Counter idles at zero outside WAIT, so every WAIT entry starts from zero.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wait_cnt  <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (r_state != c_st_wait) begin
        r_wait_cnt <= '0;
      end else if (!w_ack) begin
        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
    end
  end
`else
  logic w_unused_param;

  assign w_timeout      = 1'b0;
  assign fetch_err      = 1'b0;
  assign w_unused_param = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= c_st_idle;
      r_pc       <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_buf      <= '0;
      r_kill     <= 1'b0;
    end else begin
      r_ir_valid <= 1'b0;
      if (branch_valid) begin
        r_pc <= branch_target;
      end
      case (r_state)
        c_st_idle: begin
          if (w_fetch_permit && !branch_valid) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= c_st_wait;
          end
        end
        c_st_wait: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            // A redirect, now or earlier in this handshake, wins over loading.
            if (r_kill || branch_valid) begin
              r_kill  <= 1'b0;
              r_state <= c_st_idle;
            end else if (w_load_permit) begin
              r_ir       <= mem_rdata;
              r_ir_valid <= 1'b1;
              r_pc       <= w_pc_inc;
              r_state    <= c_st_idle;
            end else begin
              r_buf   <= mem_rdata;
              r_state <= c_st_hold;
            end
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_kill    <= 1'b0;
            r_state   <= c_st_idle;
          end else if (branch_valid) begin
            r_kill <= 1'b1;
          end
        end
        c_st_hold: begin
          if (branch_valid) begin
            r_buf   <= '0;
            r_state <= c_st_idle;
          end else if (w_load_permit) begin
            r_ir       <= r_buf;
            r_ir_valid <= 1'b1;
            r_pc       <= w_pc_inc;
            r_state    <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign ir       = r_ir;
  assign ir_valid = r_ir_valid;
  assign pc_out   = r_pc;
  assign stall    = (r_state == c_st_wait) || (r_state == c_st_hold);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_fetch_stage                                                 |
// | Brief    : Self-checking bench for fetch_stage with a simple memory model.|
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [5:0]  inst_enable = '0;
  logic        branch_valid = 1'b0;
  logic [7:0]  branch_target = '0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir;
  logic        ir_valid;
  logic [7:0]  pc_out;
  logic        stall;
  logic        fetch_err;

  int checks   = 0;
  int failures = 0;

  // Memory responder knobs: data returned is mem_base + address.
  logic        mem_on   = 1'b0;
  int          mem_lat  = 1;
  logic [15:0] mem_base = '0;
  int          mem_cnt  = 0;

  fetch_stage #(
    .ADDR_W(8), .INST_W(16), .RESET_PC(8'h00), .TIMEOUT_CYC(15)
  ) dut (
    .clk(clk), .clr(clr), .inst_enable(inst_enable),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
    .pc_out(pc_out), .stall(stall), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Ack is raised once the request has been visible for more than mem_lat cycles.
  initial forever begin
    @(posedge clk);
    #2;
    if (mem_on && mem_req && !mem_ack) begin
      mem_cnt++;
      if (mem_cnt > mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_base + {8'h00, mem_addr};
      end
    end else begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    inst_enable  = '0;
    branch_valid = 1'b0;
    mem_on       = 1'b0;
    clr          = 1'b0;
    tick();
    tick();
    #1 clr = 1'b1;
  endtask

  task automatic test_reset();
    #1 clr = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
    checks++; if (pc_out !== 8'h00) begin failures++; $display("FAIL rst_pc: got %h exp 00", pc_out); end
    tick();
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL rst_mem_addr: got %h exp 00", mem_addr); end
    checks++; if (ir !== 16'h0000 || ir_valid !== 1'b0) begin failures++; $display("FAIL rst_ir: got %h/%b exp 0000/0", ir, ir_valid); end
    checks++; if (stall !== 1'b0 || fetch_err !== 1'b0) begin failures++; $display("FAIL rst_flags: stall %b err %b exp 0 0", stall, fetch_err); end
    #1 clr = 1'b1;
  endtask

  task automatic test_hold_load();
    do_reset();
    mem_base = 16'h1234; mem_lat = 1; mem_on = 1'b1;
    inst_enable = 6'b100000;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hold_req_early: got %b exp 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00 || stall !== 1'b1) begin
      failures++; $display("FAIL hold_req: req %b addr %h stall %b exp 1 00 1", mem_req, mem_addr, stall); end
    tick();
    tick();
    tick();
    tick();
    checks++; if (stall !== 1'b1 || mem_req !== 1'b0 || ir_valid !== 1'b0) begin
      failures++; $display("FAIL hold_state: stall %b req %b v %b exp 1 0 0", stall, mem_req, ir_valid); end
    inst_enable = 6'b111111;
    tick();
    checks++; if (ir !== 16'h1234 || ir_valid !== 1'b1 || pc_out !== 8'h01) begin
      failures++; $display("FAIL hold_load: ir %h v %b pc %h exp 1234 1 01", ir, ir_valid, pc_out); end
    inst_enable = 6'b000000;
    tick();
    checks++; if (ir_valid !== 1'b0 || ir !== 16'h1234) begin
      failures++; $display("FAIL hold_pulse: ir %h v %b exp 1234 0", ir, ir_valid); end
  endtask

  task automatic test_back_to_back();
    int          cyc[$];
    logic [15:0] val[$];
    do_reset();
    mem_base = 16'h0100; mem_lat = 1; mem_on = 1'b1;
    inst_enable = 6'b111111;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (ir_valid) begin cyc.push_back(k); val.push_back(ir); end
    end
    inst_enable = 6'b000000;
    checks++; if (cyc.size() != 3) begin failures++; $display("FAIL b2b_count: got %0d exp 3", cyc.size()); end
    for (int i = 0; i < cyc.size(); i++) begin
      checks++; if (val[i] !== 16'h0100 + 16'(i) || cyc[i] != 2 + 3 * i) begin
        failures++; $display("FAIL b2b_pulse%0d: ir %h cycle %0d exp %h %0d", i, val[i], cyc[i], 16'h0100 + 16'(i), 2 + 3 * i); end
    end
    checks++; if (pc_out !== 8'h03) begin failures++; $display("FAIL b2b_pc: got %h exp 03", pc_out); end
    tick();
  endtask

  task automatic test_branch_wait();
    int n;
    do_reset();
    mem_base = 16'h0500; mem_lat = 0; mem_on = 1'b0;
    inst_enable = 6'b100000;
    tick();
    tick();
    branch_valid = 1'b1; branch_target = 8'h40;
    tick();
    branch_valid = 1'b0;
    checks++; if (pc_out !== 8'h40 || ir_valid !== 1'b0 || mem_req !== 1'b1) begin
      failures++; $display("FAIL brw_redirect: pc %h v %b req %b exp 40 0 1", pc_out, ir_valid, mem_req); end
    mem_on = 1'b1; inst_enable = 6'b110000;
    tick();
    checks++; if (ir_valid !== 1'b0 || mem_req !== 1'b0 || ir !== 16'h0000) begin
      failures++; $display("FAIL brw_discard: v %b req %b ir %h exp 0 0 0000", ir_valid, mem_req, ir); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h40) begin
      failures++; $display("FAIL brw_refetch: req %b addr %h exp 1 40", mem_req, mem_addr); end
    n = 0;
    while (!ir_valid && n < 10) begin tick(); n++; end
    inst_enable = 6'b000000;
    checks++; if (ir_valid !== 1'b1 || ir !== 16'h0540 || pc_out !== 8'h41) begin
      failures++; $display("FAIL brw_load: v %b ir %h pc %h exp 1 0540 41", ir_valid, ir, pc_out); end
    tick();
  endtask

  task automatic test_branch_ack_same();
    do_reset();
    mem_base = 16'h0700; mem_lat = 1; mem_on = 1'b1;
    inst_enable = 6'b110000;
    tick();
    inst_enable = 6'b010000;
    tick();
    branch_valid = 1'b1; branch_target = 8'h20;
    tick();
    branch_valid = 1'b0; inst_enable = 6'b000000;
    checks++; if (pc_out !== 8'h20 || ir !== 16'h0000 || ir_valid !== 1'b0 || mem_req !== 1'b0) begin
      failures++; $display("FAIL bra_same: pc %h ir %h v %b req %b exp 20 0000 0 0", pc_out, ir, ir_valid, mem_req); end
    tick();
  endtask

  task automatic test_pc_wrap();
    int n;
    do_reset();
    branch_valid = 1'b1; branch_target = 8'hFF;
    tick();
    branch_valid = 1'b0;
    mem_base = 16'h0A00; mem_lat = 1; mem_on = 1'b1;
    inst_enable = 6'b110000;
    n = 0;
    while (!ir_valid && n < 10) begin tick(); n++; end
    inst_enable = 6'b000000;
    checks++; if (ir_valid !== 1'b1 || ir !== 16'h0AFF || pc_out !== 8'h00) begin
      failures++; $display("FAIL wrap: v %b ir %h pc %h exp 1 0AFF 00", ir_valid, ir, pc_out); end
    tick();
  endtask

  task automatic test_clr_mid();
    do_reset();
    branch_valid = 1'b1; branch_target = 8'h33;
    tick();
    branch_valid = 1'b0;
    inst_enable = 6'b100000;
    tick();
    inst_enable = 6'b000000;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h33) begin
      failures++; $display("FAIL clr_pre: req %b addr %h exp 1 33", mem_req, mem_addr); end
    #3 clr = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || pc_out !== 8'h00 || mem_addr !== 8'h00 || stall !== 1'b0) begin
      failures++; $display("FAIL clr_async: req %b pc %h addr %h stall %b exp 0 00 00 0", mem_req, pc_out, mem_addr, stall); end
    mem_on = 1'b1; mem_lat = 0;
    tick();
    #1 clr = 1'b1;
    tick();
    tick();
    checks++; if (mem_req !== 1'b0 || ir_valid !== 1'b0 || pc_out !== 8'h00) begin
      failures++; $display("FAIL clr_after: req %b v %b pc %h exp 0 0 00", mem_req, ir_valid, pc_out); end
  endtask

  // Reference: each load carries the word at the current PC; branches move the PC.
  task automatic test_random();
    logic [7:0] exp_pc;
    logic [7:0] old_pc;
    logic [7:0] tgt;
    logic [5:0] en;
    logic       br;
    int         loads;
    do_reset();
    exp_pc = 8'h00; loads = 0;
    mem_base = 16'h3C00; mem_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      en = 6'($urandom);
      if ($urandom_range(0, 3) != 0) en[5] = 1'b1;
      if ($urandom_range(0, 3) != 0) en[4] = 1'b1;
      br  = ($urandom_range(0, 9) == 0);
      tgt = 8'($urandom);
      mem_lat = $urandom_range(0, 3);
      inst_enable = en; branch_valid = br; branch_target = tgt;
      old_pc = exp_pc;
      tick();
      if (br) exp_pc = tgt;
      if (ir_valid) begin
        loads++;
        checks++; if (br || !en[4]) begin
          failures++; $display("FAIL rnd_valid@%0d: pulse with branch %b permit %b", i, br, en[4]); end
        checks++; if (ir !== mem_base + {8'h00, old_pc}) begin
          failures++; $display("FAIL rnd_ir@%0d: got %h exp %h", i, ir, mem_base + {8'h00, old_pc}); end
        if (!br) exp_pc = old_pc + 8'h01;
      end
      checks++; if (pc_out !== exp_pc) begin
        failures++; $display("FAIL rnd_pc@%0d: got %h exp %h", i, pc_out, exp_pc); end
    end
    inst_enable = '0; branch_valid = 1'b0;
    checks++; if (loads < 10) begin failures++; $display("FAIL rnd_loads: got %0d exp >=10", loads); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL rnd_err: got %b exp 0", fetch_err); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int hi;
    do_reset();
    mem_on = 1'b0;
    inst_enable = 6'b100000;
    tick();
    inst_enable = 6'b000000;
    hi = 0;
    while (mem_req && hi < 40) begin hi++; tick(); end
    checks++; if (hi != 15) begin failures++; $display("FAIL to_len: req cycles %0d exp 15", hi); end
    checks++; if (fetch_err !== 1'b1 || pc_out !== 8'h00 || stall !== 1'b0) begin
      failures++; $display("FAIL to_flags: err %b pc %h stall %b exp 1 00 0", fetch_err, pc_out, stall); end
    tick();
    tick();
    tick();
    checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b exp 1", fetch_err); end
    mem_on = 1'b1; mem_lat = 1;
    inst_enable = 6'b100000;
    tick();
    inst_enable = 6'b000000;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      failures++; $display("FAIL to_retry: req %b addr %h exp 1 00", mem_req, mem_addr); end
    tick();
    tick();
    tick();
    do_reset();
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL to_clear: got %b exp 0", fetch_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_hold_load();
    test_back_to_back();
    test_branch_wait();
    test_branch_ack_same();
    test_pc_wrap();
    test_clr_mid();
    test_random();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage driven directly by the central control unit's 6-bit instruction-enable vector.
- Holds the program counter and runs a req/ack read handshake to instruction memory.
- Buffers a returned word until the control unit permits an IR load, then presents it in the instruction register to the downstream decode stage.
- Also takes branch redirects from downstream.

Parameters:
ADDR_W, 8, program counter / memory address width
INST_W, 16, instruction word width
RESET_PC, 0, PC value after reset (must fit in ADDR_W)
TIMEOUT_CYC, 15, max cycles waiting for mem_ack (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  clock, all state on rising edge
clr  input  1  reset, asynchronous, active-low
inst_enable  input  6  enable vector from control unit; [5]=fetch permit, [4]=IR load permit, [3:0] ignored here
branch_valid  input  1  one-cycle redirect request
branch_target  input  ADDR_W  redirect address
mem_req  output  1  memory read request
mem_addr  output  ADDR_W  memory read address
mem_ack  input  1  read data valid, sampled only while mem_req=1
mem_rdata  input  INST_W  read data
ir  output  INST_W  instruction register
ir_valid  output  1  one-cycle pulse when ir is newly loaded
pc_out  output  ADDR_W  current PC
stall  output  1  high while in WAIT or HOLD
fetch_err  output  1  sticky timeout flag (0 when feature is compiled out)

Behaviour:
- Reset (clr=0, async):
  - pc=RESET_PC, mem_addr=RESET_PC.
  - mem_req=0, ir=0, ir_valid=0, buf=0, kill=0, fetch_err=0.
  - State=IDLE.
  - clr low mid-handshake drops mem_req immediately; a late mem_ack is ignored.
- States: IDLE, WAIT, HOLD. stall = (state==WAIT || state==HOLD), combinational.
- IDLE:
  - If inst_enable[5]=1 and branch_valid=0, register mem_req=1 and mem_addr=pc, and go to WAIT.
  - mem_req is asserted the cycle after the enable is sampled.
- WAIT:
  - mem_req and mem_addr stay stable until mem_ack=1 is sampled. On that edge mem_req goes to 0.
  - If kill=1 or branch_valid=1: discard data, clear kill, go to IDLE.
  - Else if inst_enable[4]=1: ir=mem_rdata, ir_valid=1, pc=pc+1, go to IDLE.
  - Else: buf=mem_rdata, go to HOLD.
- HOLD: when inst_enable[4]=1, ir=buf, ir_valid=1, pc=pc+1, go to IDLE.
- ir_valid is high for exactly one cycle per load. ir holds its value until the next load.
- PC increments modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- Branch (branch_valid=1, any state):
  - pc=branch_target on the next edge; ir_valid=0 that cycle.
  - WAIT without ack this cycle: set kill and keep the handshake alive until ack, then discard the data.
  - HOLD: drop buf, go to IDLE.
  - Branch has priority over an ack-load in the same cycle.
  - The next fetch uses the new pc.
- inst_enable=000000 (control-unit bubble/reset): no new request. An in-flight request still completes into buf/HOLD.
- inst_enable[3:0] has no effect.
- Back-to-back fetch: with inst_enable=111111 and ack one cycle after req, one instruction every 3 cycles.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYC without ack: mem_req=0, fetch_err=1 (sticky until clr), go to IDLE, pc unchanged.
  - A subsequent fetch retries the same address.
- Not defined: no counter, WAIT is unbounded, fetch_err is tied to 0.

Test Plan:
- Reset then inst_enable=100000, memory acks in 1 cycle with 0x1234 -> mem_req rises 1 cycle after enable, mem_addr=0; HOLD with stall=1; then inst_enable=111111 -> ir=0x1234, ir_valid one pulse, pc_out=1.
- inst_enable=111111 held, ack latency 1, memory returns address+0x100 -> ir sequence 0x100, 0x101, 0x102, one ir_valid pulse every 3 cycles.
- Branch in WAIT: branch_valid with target 0x40 while awaiting ack -> acked data discarded, no ir_valid, next mem_addr=0x40.
- Branch and ack in the same cycle -> pc_out=target, ir unchanged, ir_valid=0.
- pc=0xFF (ADDR_W=8), one load -> pc_out=0x00. Separately, clr pulsed low during WAIT -> mem_req=0 asynchronously, pc_out=RESET_PC.
- FETCH_TIMEOUT_EN defined, never ack -> mem_req drops after 15 WAIT cycles, fetch_err=1 until clr; the retry uses the same mem_addr.
